// File: rtl/cmp_arbiter_if.sv
// cmp_arbiter_if
//   Bundle between the requesters, the shared signed comparator and the
//   cmp_arbiter sequencer.
//
//   Request side : req_valid, req_ready, req_a, req_b, req_oper
//                  (per-requester slices: [i*WIDTH +: WIDTH], [i*3 +: 3])
//   Response side: rsp_valid (one-hot pulse), rsp_result, rsp_err
//   Comparator   : cmp_a, cmp_b, cmp_oper (registered), cmp_val (result)
//
//   slave  : the arbiter's view
//   master : the requesters' plus comparator's view
interface cmp_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH-1:0]   req_a;
  logic [NREQ*WIDTH-1:0]   req_b;
  logic [NREQ*3-1:0]       req_oper;
  logic [NREQ-1:0]         rsp_valid;
  logic                    rsp_result;
  logic                    rsp_err;
  logic signed [WIDTH-1:0] cmp_a;
  logic signed [WIDTH-1:0] cmp_b;
  logic [2:0]              cmp_oper;
  logic                    cmp_val;

  modport slave (
    input  req_valid, req_a, req_b, req_oper, cmp_val,
    output req_ready, rsp_valid, rsp_result, rsp_err, cmp_a, cmp_b, cmp_oper
  );

  modport master (
    output req_valid, req_a, req_b, req_oper, cmp_val,
    input  req_ready, rsp_valid, rsp_result, rsp_err, cmp_a, cmp_b, cmp_oper
  );
endinterface

// File: rtl/cmp_arbiter.sv
// cmp_arbiter
//   Round-robin arbiter/sequencer sharing one signed comparator among NREQ
//   requesters (NREQ legal range 2..4). One compare is in flight at a time:
//   accept (IDLE) -> operands stable at the comparator, result captured
//   (ISSUE) -> one-cycle response pulse to the owner (RESP).
//
//   Ports
//     clk   : clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : cmp_arbiter_if.slave (request, response and comparator signals)
//
//   Optional feature macro: CMP_ARB_ERR_EN
//     defined   : illegal opcodes (110/111) are accepted, the comparator sees
//                 000, the response carries rsp_result=0 and rsp_err=1.
//     undefined : opcodes pass through unmodified, rsp_err is tied to 0.
module cmp_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  cmp_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win_idx_p0;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   rr_nxt;
  logic               pick_found;
  logic               accept;
  logic [WIDTH-1:0]   pick_a;
  logic [WIDTH-1:0]   pick_b;
  logic [2:0]         pick_oper;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = PTR_W'(cand);
      if (!pick_found && bus.req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign rr_nxt    = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
  assign pick_a    = bus.req_a[pick_idx*WIDTH +: WIDTH];
  assign pick_b    = bus.req_b[pick_idx*WIDTH +: WIDTH];
  assign pick_oper = bus.req_oper[pick_idx*3 +: 3];

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: ready is purely a function of state, rr_ptr and req_valid
  always_comb begin
    accept        = (state == IDLE) && pick_found;
    bus.req_ready = '0;
    if (accept) bus.req_ready[pick_idx] = 1'b1;
  end

`ifdef CMP_ARB_ERR_EN
  logic err_p0;
  logic pick_illegal;

  assign pick_illegal = (pick_oper[2:1] == 2'b11);
`endif

  // Stage p0: latch winner operands at accept.
  // Stage p1: capture comparator result in ISSUE; response pulse registered
  //           so it is present during RESP even if reset arrives then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      win_idx_p0     <= '0;
      bus.cmp_a      <= '0;
      bus.cmp_b      <= '0;
      bus.cmp_oper   <= '0;
      bus.rsp_valid  <= '0;
      bus.rsp_result <= 1'b0;
`ifdef CMP_ARB_ERR_EN
      err_p0         <= 1'b0;
      bus.rsp_err    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        rr_ptr     <= rr_nxt;
        win_idx_p0 <= pick_idx;
        bus.cmp_a  <= pick_a;
        bus.cmp_b  <= pick_b;
`ifdef CMP_ARB_ERR_EN
        // Illegal opcode still runs the full sequence; comparator sees ==.
        err_p0       <= pick_illegal;
        bus.cmp_oper <= pick_illegal ? 3'b000 : pick_oper;
`else
        bus.cmp_oper <= pick_oper;
`endif
      end

      bus.rsp_valid <= '0;
      if (state == ISSUE) begin
        bus.rsp_valid[win_idx_p0] <= 1'b1;
`ifdef CMP_ARB_ERR_EN
        bus.rsp_result <= bus.cmp_val & ~err_p0;
        bus.rsp_err    <= err_p0;
`else
        bus.rsp_result <= bus.cmp_val;
`endif
      end
    end
  end

`ifndef CMP_ARB_ERR_EN
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Round-robin arbiter and sequencer that shares the single signed 32-bit comparator between several requesters, such as the branch unit and the set-less-than path. It accepts one compare request at a time over a valid/ready handshake and drives registered operands and opcode into the comparator. It captures the comparator's single-bit result and returns it to the winning requester as a one-cycle response pulse.

## Interface
- Parameter `NREQ`, default 2: number of requesters, legal range 2..4.
- Parameter `WIDTH`, default 32: operand width; must match the comparator.
- `clk` input 1: the only clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `req_valid` input NREQ: bit i set means requester i has a compare pending.
- `req_ready` output NREQ: one-hot; bit i set means requester i's request is accepted this cycle.
- `req_a` input NREQ*WIDTH: operand A for requester i, in slice [i*WIDTH +: WIDTH]; signed.
- `req_b` input NREQ*WIDTH: operand B for requester i, in the same slice layout; signed.
- `req_oper` input NREQ*3: opcode for requester i, in slice [i*3 +: 3].
- `rsp_valid` output NREQ: one-hot, one-cycle pulse to the requester that owns `rsp_result`.
- `rsp_result` output 1: captured comparator result.
- `rsp_err` output 1: illegal-opcode flag, qualified by `rsp_valid`.
- `cmp_a` output WIDTH: registered operand A to the comparator.
- `cmp_b` output WIDTH: registered operand B to the comparator.
- `cmp_oper` output 3: registered opcode to the comparator.
- `cmp_val` input 1: comparator result, combinational from `cmp_*`.

## Operation
- Opcode encoding:
  - 000 `==`, 001 `!=`, 010 `<`, 011 `<=`, 100 `>`, 101 `>=`.
  - All comparisons are signed two's-complement.
  - 110 and 111 are illegal.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any `req_valid` bit is set, pick the winner round-robin.
  - The search starts at pointer `rr_ptr` and takes the first set bit at or after it, wrapping.
  - Assert `req_ready[winner]`. The handshake completes at that edge.
  - Latch the winner's operands and opcode into `cmp_*`, store the winner index, and go to ISSUE.
  - Set `rr_ptr` to winner+1, wrapping to 0 at NREQ.
- ISSUE:
  - `cmp_*` are stable; capture `cmp_val` into `rsp_result`.
  - Go to RESP.
- RESP:
  - Assert `rsp_valid[winner]` for exactly one cycle.
  - Go to IDLE.
- `req_ready` is 0 in ISSUE and RESP. Requests that stay valid during that time are held and arbitrated later.
- `req_ready` depends only on state, `rr_ptr` and `req_valid`. It never depends on `cmp_val`.
- `cmp_*` keep their last issued values outside ISSUE. There is no toggling while idle.
- If the winner deasserts `req_valid` after the handshake, the in-flight operation is unaffected.

## Timing
- Reset: on any rising edge with `rst_n`=0, the following apply:
  - state goes to IDLE and `rr_ptr` to 0.
  - `req_ready`, `rsp_valid`, `rsp_result`, `rsp_err`, `cmp_a`, `cmp_b` and `cmp_oper` all go to 0.
  - Any in-flight operation is discarded with no response.
- Latency: a request accepted in cycle T gets `rsp_valid` in cycle T+2.
- Throughput: at most one operation every 3 cycles. The next accept can happen no earlier than T+3.
- Simultaneous requests: exactly one is granted. With all requesters valid continuously, grants rotate 0,1,...,NREQ-1,0.
- A lone requester is granted on every accept opportunity, regardless of `rr_ptr`.
- Reset asserted in the RESP cycle: the pulse still appears in that cycle because it is a registered output. No further pulse follows.

## Configuration
- `CMP_ARB_ERR_EN` defined:
  - An illegal opcode (110/111) is still accepted and takes the same 3-cycle path.
  - `cmp_oper` is driven 000 instead of the illegal value.
  - `rsp_result` is forced to 0 and `rsp_err` is 1 in the RESP cycle.
- `CMP_ARB_ERR_EN` undefined:
  - The opcode passes through unmodified.
  - `rsp_result` is whatever the comparator returns.
  - `rsp_err` is tied to 0.

## Test plan
- Single requester 0 sends a=2, b=3, oper=010 in cycle T: `req_ready[0]` is high in T, and `rsp_valid[0]` with `rsp_result`=1 is high in T+2.
- Negative operands a=-2, b=-3 with oper=100 give result 1; a=-2, b=-2 with oper=000 gives result 1; a=2, b=-3 with oper=010 gives result 0.
- Both requesters valid continuously: grants alternate 0,1,0,1 at 3-cycle spacing. Requester 1 with a=3, b=3, oper=101 returns 1. Each response goes only to its owner.
- Requester 1 drops `req_valid` one cycle after its handshake: its response still arrives at T+2 with the correct result.
- `rst_n` driven low in the ISSUE cycle: no `rsp_valid` follows, every output reads 0, and the next request is accepted normally with `rr_ptr`=0.
- oper=111: with `CMP_ARB_ERR_EN` the response is `rsp_err`=1, `rsp_result`=0, and `cmp_oper`=000 during ISSUE. Without it, `rsp_err` stays 0.
